// File: rtl/rate_ctrl_pkg.sv
// Shared types and constants for the rate controller.
package rate_ctrl_pkg;

  localparam int RATE_W = 2;
  localparam logic [RATE_W-1:0] RATE_MAX = 2'd3;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // Saturating up/down step of the requested rate; simultaneous requests cancel.
  function automatic logic [RATE_W-1:0] rate_step(input logic [RATE_W-1:0] req,
                                                  input logic up,
                                                  input logic down);
    logic [RATE_W-1:0] r;
    r = req;
    if (up && !down && req != RATE_MAX) r = req + 1'b1;
    else if (down && !up && req != '0) r = req - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rate_ctrl_if.sv
// Request/status bundle between the button side and the rate controller.
interface rate_ctrl_if;
  import rate_ctrl_pkg::*;

  logic              run_i;
  logic              up_i;
  logic              down_i;
  logic              tick_o;
  logic              clk_div_o;
  logic [RATE_W-1:0] rate_o;
  logic              running_o;
  logic              pending_o;

  modport master (
    output run_i, up_i, down_i,
    input  tick_o, clk_div_o, rate_o, running_o, pending_o
  );

  modport slave (
    input  run_i, up_i, down_i,
    output tick_o, clk_div_o, rate_o, running_o, pending_o
  );

endinterface

// File: rtl/rate_ctrl_btn_cond.sv
// Push-button conditioner: 2-FF synchronizer, stable-time debouncer and
// rising-edge pulse. Only instantiated when RATE_CTRL_DEBOUNCE_EN is defined.
module btn_cond #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn,
  output logic pulse
);

  localparam int TMR_W = $clog2(DEB_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic [TMR_W-1:0] tmr;

  // Synchronize, then accept a new level only after DEB_CYCLES differing samples.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync  <= '0;
      level <= 1'b0;
      tmr   <= TMR_LOAD;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        tmr <= TMR_LOAD;
      end else if (tmr == '0) begin
        level <= sync[1];
        tmr   <= TMR_LOAD;
        pulse <= sync[1];
      end else begin
        tmr <= tmr - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rate_ctrl.sv
// Run/pause and rate controller with programmable clock divider.
// Optional input conditioning is enabled with `define RATE_CTRL_DEBOUNCE_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | counter advances, wraps emit tick and toggle clk_div
// ST_PAUSED | counter and clk_div frozen, rate requests apply at once
module rate_ctrl
  import rate_ctrl_pkg::*;
#(
  parameter int BASE_LIMIT = 49_999_999,
  parameter int CNT_W      = 26,
  parameter int DEB_CYCLES = 1_000_000
) (
  input logic        clk_i,
  input logic        rst_i,
  rate_ctrl_if.slave bus
);

  localparam logic [CNT_W:0] BASE_P1 = (CNT_W + 1)'(BASE_LIMIT + 1);

  if (BASE_LIMIT >= (1 << CNT_W) || DEB_CYCLES < 1) begin : g_bad_param
    $error("rate_ctrl: BASE_LIMIT must fit in CNT_W bits and DEB_CYCLES must be >= 1");
  end

  logic              run_req;
  logic              up_req;
  logic              down_req;
  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  limit;
  logic              wrap;
  logic              clk_div;
  logic              tick;
  logic              pending;
  logic [RATE_W-1:0] rate_act;
  logic [RATE_W-1:0] rate_req;
  logic [RATE_W-1:0] rate_req_nxt;
  logic [RATE_W-1:0] rate_act_nxt;

`ifdef RATE_CTRL_DEBOUNCE_EN
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_run  (.clk_i(clk_i), .rst_i(rst_i), .btn(bus.run_i),  .pulse(run_req));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_up   (.clk_i(clk_i), .rst_i(rst_i), .btn(bus.up_i),   .pulse(up_req));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_down (.clk_i(clk_i), .rst_i(rst_i), .btn(bus.down_i), .pulse(down_req));
`else
  assign run_req  = bus.run_i;
  assign up_req   = bus.up_i;
  assign down_req = bus.down_i;
`endif

  // Half-period terminal count shrinks by a power of two per rate step.
  assign limit = CNT_W'((BASE_P1 >> rate_act) - 1'b1);

  // ">=" rather than "==" so a rate raised while paused, leaving count past
  // the new limit, ends the half-period on the first running cycle.
  assign wrap = (count >= limit);

  // Next requested rate and when the active rate may follow it.
  always_comb begin
    rate_req_nxt = rate_step(rate_req, up_req, down_req);
    rate_act_nxt = rate_act;
    if (state == ST_PAUSED || wrap) rate_act_nxt = rate_req_nxt;
  end

  // Run/pause FSM with divider counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_RUN;
      count    <= '0;
      clk_div  <= 1'b0;
      tick     <= 1'b0;
      rate_act <= '0;
      rate_req <= '0;
      pending  <= 1'b0;
    end else begin
      rate_req <= rate_req_nxt;
      rate_act <= rate_act_nxt;
      pending  <= (rate_req_nxt != rate_act_nxt);
      case (state)
        ST_RUN: begin
          if (wrap) begin
            count   <= '0;
            tick    <= 1'b1;
            clk_div <= ~clk_div;
          end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
          end
          if (run_req) state <= ST_PAUSED;
        end
        ST_PAUSED: begin
          tick <= 1'b0;
          if (run_req) state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          tick  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick_o    = tick;
  assign bus.clk_div_o = clk_div;
  assign bus.rate_o    = rate_act;
  assign bus.running_o = (state == ST_RUN);
  assign bus.pending_o = pending;

endmodule

// File: tb/tb_rate_ctrl.sv
// Self-checking bench for rate_ctrl with BASE_LIMIT=15, debounce disabled.
module tb_rate_ctrl;
  import rate_ctrl_pkg::*;

  localparam int BASE_LIMIT = 15;
  localparam int CNT_W      = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  rate_ctrl_if bus();

  rate_ctrl #(.BASE_LIMIT(BASE_LIMIT), .CNT_W(CNT_W), .DEB_CYCLES(4)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model state: position inside the half-period, divider level,
  // last tick, active/requested rate, running flag.
  int m_pos, m_div, m_tick, m_act, m_req, m_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_div = 0; m_tick = 0; m_act = 0; m_req = 0; m_run = 1;
  endtask

  // One clock of the specified behaviour, in plain integer arithmetic.
  task automatic model_step(input bit run, input bit up, input bit down);
    int new_req;
    int half_len;
    new_req = m_req;
    if (up && !down) new_req = (m_req < 3) ? m_req + 1 : 3;
    if (down && !up) new_req = (m_req > 0) ? m_req - 1 : 0;
    m_tick = 0;
    if (m_run == 1) begin
      half_len = (BASE_LIMIT + 1) / (2 ** m_act);
      if (m_pos + 1 >= half_len) begin
        m_pos = 0; m_tick = 1; m_div = 1 - m_div; m_act = new_req;
      end else begin
        m_pos = m_pos + 1;
      end
      if (run) m_run = 0;
    end else begin
      m_act = new_req;
      if (run) m_run = 1;
    end
    m_req = new_req;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".tick"},    bus.tick_o,    m_tick);
    check({tag, ".div"},     bus.clk_div_o, m_div);
    check({tag, ".rate"},    bus.rate_o,    m_act);
    check({tag, ".running"}, bus.running_o, m_run);
    check({tag, ".pending"}, bus.pending_o, (m_req != m_act) ? 1 : 0);
  endtask

  task automatic cycle(input bit run, input bit up, input bit down);
    bus.run_i = run; bus.up_i = up; bus.down_i = down;
    @(posedge clk_i);
    model_step(run, up, down);
    #1;
    bus.run_i = 1'b0; bus.up_i = 1'b0; bus.down_i = 1'b0;
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Idle until the DUT ticks; n = cycles taken. Bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end while (!bus.tick_o && n < 100);
    if (n >= 100) check("tick_timeout", bus.tick_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ticks;
    bus.run_i = 1'b0; bus.up_i = 1'b0; bus.down_i = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk_i) rst_i = 1'b1;

    // 1: base rate, tick every 16, divider period 32
    wait_tick(n);
    check("t1_first_tick", n, 16);
    check("t1_div_hi", bus.clk_div_o, 1);
    wait_tick(n);
    check("t1_gap", n, 16);
    check("t1_div_lo", bus.clk_div_o, 0);

    // 2: up at count 5, applied at the wrap
    idle(5);
    cycle(1'b0, 1'b1, 1'b0);
    check("t2_pending", bus.pending_o, 1);
    check("t2_rate_held", bus.rate_o, 0);
    wait_tick(n);
    check("t2_apply_delay", n, 10);
    check("t2_rate", bus.rate_o, 1);
    check("t2_pending_clr", bus.pending_o, 0);
    wait_tick(n);
    check("t2_gap", n, 8);

    // 3: saturate at 3, simultaneous up+down ignored
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) wait_tick(n);
    check("t3_gap", n, 2);
    check("t3_rate", bus.rate_o, 3);

    // 4: pause at count 7, rate moves while paused, resume from 8
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    wait_tick(n);
    wait_tick(n);
    check("t4_rate0", bus.rate_o, 0);
    idle(7);
    cycle(1'b1, 1'b0, 1'b0);
    check("t4_paused", bus.running_o, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (bus.tick_o) ticks++;
    end
    check("t4_no_ticks", ticks, 0);
    cycle(1'b0, 1'b1, 1'b0);
    check("t4_up_paused", bus.rate_o, 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("t4_down_paused", bus.rate_o, 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t4_resumed", bus.running_o, 1);
    wait_tick(n);
    check("t4_resume_gap", n, 8);

    // 5: pause exactly on the wrap
    idle(15);
    cycle(1'b1, 1'b0, 1'b0);
    check("t5_tick", bus.tick_o, 1);
    check("t5_paused", bus.running_o, 0);
    idle(5);
    cycle(1'b1, 1'b0, 1'b0);
    wait_tick(n);
    check("t5_resume_gap", n, 16);

    // 6: async reset mid-period with clk_div=1 at rate 2
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6 && !(bus.rate_o == 2 && bus.clk_div_o == 1); i++) wait_tick(n);
    check("t6_pre_rate", bus.rate_o, 2);
    check("t6_pre_div", bus.clk_div_o, 1);
    idle(2);
    #3 rst_i = 1'b0;
    #1;
    model_reset();
    compare_all("t6_async");
    @(posedge clk_i);
    #1;
    compare_all("t6_hold");
    @(negedge clk_i) rst_i = 1'b1;
    wait_tick(n);
    check("t6_first_tick", n, 16);
    wait_tick(n);
    check("t6_gap", n, 16);

    // Randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      bit r, u, d;
      r = ($urandom_range(0, 39) == 0);
      u = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 7) == 0);
      cycle(r, u, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
